// File: rtl/armaria_pkg.sv
// Shared definitions for the memory address handler: op encoding, FSM states
// and the architectural reset values of PC and SP.
package armaria_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_PUSH   = 3'd4;
    localparam logic [2:0] OP_POP    = 3'd5;
    localparam logic [2:0] OP_EXCEPT = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0002;
    localparam logic [31:0] RST_PC         = 32'h0000_0001;
    localparam logic [31:0] RST_SP         = 32'hFFFF_FFFF;

    function automatic logic is_read_op(input logic [2:0] o);
        return (o == OP_LOAD) || (o == OP_POP);
    endfunction

    function automatic logic is_write_op(input logic [2:0] o);
        return (o == OP_STORE) || (o == OP_PUSH);
    endfunction

endpackage

// File: rtl/mem_addr_handler_if.sv
// Memory port of the address handler: word address, write data, strobes,
// read data and the single ready/acknowledge line.
interface mem_addr_handler_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ready;

    modport master (output mem_addr, mem_wdata, mem_re, mem_we,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_addr, mem_wdata, mem_re, mem_we,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/next_addr_calc.sv
// Combinational next-PC / next-SP / access-address computation for one op.
module next_addr_calc
    import armaria_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [2:0]  op_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] sp_i,
    input  logic [31:0] result_i,
    input  logic        fault_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] next_sp_o,
    output logic [31:0] acc_addr_o
);

    always_comb begin
        next_pc_o  = pc_i + 32'd1;
        next_sp_o  = sp_i;
        acc_addr_o = result_i;
        // The stack grows downward: PUSH pre-decrements, POP reads then increments.
        case (op_i)
            OP_PUSH: acc_addr_o = sp_i - 32'd1;
            OP_POP:  acc_addr_o = sp_i;
            default: acc_addr_o = result_i;
        endcase
        if (fault_i) begin
            next_pc_o = EXC_VECTOR;
        end else begin
            case (op_i)
                OP_BRANCH: next_pc_o = result_i;
                OP_EXCEPT: next_pc_o = EXC_VECTOR;
                OP_PUSH:   next_sp_o = sp_i - 32'd1;
                OP_POP:    next_sp_o = sp_i + 32'd1;
                default:   next_pc_o = pc_i + 32'd1;
            endcase
        end
    end

endmodule

// File: rtl/mem_addr_handler.sv
// Sequences one fetch/data access per start and commits PC, SP and load data
// to the register bank with a single-cycle enable pulse.
module mem_addr_handler
    import armaria_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_8000,
    parameter int          WAIT_LIMIT  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [31:0]        PC,
    input  logic [31:0]        SP,
    input  logic [31:0]        Result,
    input  logic [31:0]        B,
    mem_addr_handler_if.master mem,
    output logic [31:0]        PCin,
    output logic [31:0]        SPin,
    output logic [31:0]        MemIn,
    output logic               bank_enable,
    output logic               busy,
    output logic               fault
);

    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    state_e            state_q, state_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [2:0]        op_q;
    logic [31:0]       pc_q, sp_q, res_q, b_q;
    logic [31:0]       mem_addr_q, mem_wdata_q, pcin_q, spin_q, memin_q;
    logic              mem_re_q, mem_we_q, bank_en_q, busy_q, fault_q;

    logic              in_idle, early_fault, timeout, c_fault;
    logic [2:0]        c_op;
    logic [31:0]       c_pc, c_sp, c_res, c_b;
    logic [31:0]       next_pc, next_sp, acc_addr;

    // In IDLE the operands are still on the inputs; afterwards use the latched copy.
    assign in_idle     = (state_q == ST_IDLE);
    assign c_op        = in_idle ? op     : op_q;
    assign c_pc        = in_idle ? PC     : pc_q;
    assign c_sp        = in_idle ? SP     : sp_q;
    assign c_res       = in_idle ? Result : res_q;
    assign c_b         = in_idle ? B      : b_q;
    assign early_fault = ((op == OP_PUSH) && (SP == STACK_LIMIT)) ||
                         ((op == OP_POP)  && (SP == 32'hFFFF_FFFF));
    assign timeout     = (state_q == ST_ACCESS) && !mem.mem_ready &&
                         (wait_q == WCW'(WAIT_LIMIT));
    assign c_fault     = in_idle ? early_fault : timeout;

    next_addr_calc #(.EXC_VECTOR(EXC_VECTOR)) u_calc (
        .op_i       (c_op),
        .pc_i       (c_pc),
        .sp_i       (c_sp),
        .result_i   (c_res),
        .fault_i    (c_fault),
        .next_pc_o  (next_pc),
        .next_sp_o  (next_sp),
        .acc_addr_o (acc_addr)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((is_read_op(op) || is_write_op(op)) && !early_fault)
                        state_d = ST_ACCESS;
                    else
                        state_d = ST_COMMIT;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ready || timeout) begin
                    state_d = ST_COMMIT;
                    wait_d  = '0;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (in_idle && start) begin
            op_q  <= op;
            pc_q  <= PC;
            sp_q  <= SP;
            res_q <= Result;
            b_q   <= B;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            bank_en_q   <= 1'b0;
            fault_q     <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pcin_q      <= RST_PC;
            spin_q      <= RST_SP;
            memin_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            busy_q    <= (state_d != ST_IDLE);
            bank_en_q <= (state_d == ST_COMMIT);
            if (state_d == ST_ACCESS) begin
                mem_re_q    <= is_read_op(c_op);
                mem_we_q    <= is_write_op(c_op);
                mem_addr_q  <= acc_addr;
                mem_wdata_q <= c_b;
            end else begin
                mem_re_q <= 1'b0;
                mem_we_q <= 1'b0;
            end
            if ((state_q == ST_ACCESS) && mem.mem_ready && is_read_op(op_q))
                memin_q <= mem.mem_rdata;
            if (state_d == ST_COMMIT) begin
                pcin_q  <= next_pc;
                spin_q  <= next_sp;
                fault_q <= c_fault;
            end else begin
                fault_q <= 1'b0;
            end
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_re    = mem_re_q;
    assign mem.mem_we    = mem_we_q;
    assign PCin          = pcin_q;
    assign SPin          = spin_q;
    assign MemIn         = memin_q;
    assign bank_enable   = bank_en_q;
    assign busy          = busy_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_mem_addr_handler.sv
// Randomized and directed bench for mem_addr_handler with a behavioural model.
module tb_mem_addr_handler;

    localparam logic [31:0] EXC = 32'h0000_0002;
    localparam logic [31:0] LIM = 32'h0000_8000;
    localparam int          WL  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] PC = 32'd0, SP = 32'd0, Result = 32'd0, B = 32'd0;
    logic [31:0] PCin, SPin, MemIn;
    logic        bank_enable, busy, fault;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_memin;

    mem_addr_handler_if mif();

    mem_addr_handler #(.EXC_VECTOR(EXC), .STACK_LIMIT(LIM), .WAIT_LIMIT(WL)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .PC          (PC),
        .SP          (SP),
        .Result      (Result),
        .B           (B),
        .mem         (mif),
        .PCin        (PCin),
        .SPin        (SPin),
        .MemIn       (MemIn),
        .bank_enable (bank_enable),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural outcome of one operation; rdy = ready after that many wait cycles, <0 never.
    function automatic void model(input logic [2:0] o, input logic [31:0] pc, sp, res,
                                  input int rdy, input logic [31:0] rd,
                                  output logic [31:0] epc, esp, eaddr,
                                  output logic ef, ere, ewe, output int elat, estr);
        bit memop, early, tmo;
        memop = (o >= 3'd2) && (o <= 3'd5);
        early = (o == 3'd4 && sp == LIM) || (o == 3'd5 && sp == 32'hFFFF_FFFF);
        tmo   = memop && !early && (rdy < 0 || rdy > WL);
        ef    = early || tmo;
        ere   = memop && !early && (o == 3'd2 || o == 3'd5);
        ewe   = memop && !early && (o == 3'd3 || o == 3'd4);
        eaddr = (o == 3'd4) ? sp - 1 : (o == 3'd5) ? sp : res;
        if (!memop || early) begin elat = 1; estr = 0; end
        else if (tmo)        begin elat = WL + 2; estr = WL + 1; end
        else                 begin elat = rdy + 2; estr = rdy + 1; end
        esp = sp;
        if (ef) epc = EXC;
        else begin
            epc = (o == 3'd1) ? res : (o == 3'd6) ? EXC : pc + 1;
            if (o == 3'd4) esp = sp - 1;
            if (o == 3'd5) esp = sp + 1;
        end
        if (!ef && (o == 3'd2 || o == 3'd5)) m_memin = rd;
    endfunction

    // Issues one op and plays the memory side; returns at the COMMIT cycle (negedge).
    task automatic do_op(input logic [2:0] o, input logic [31:0] pc, sp, res, b,
                         input int rdy, input logic [31:0] rd, input bit hold,
                         output int lat, output int nstr, output logic [31:0] a_s, w_s,
                         output logic re_s, we_s, output bit unstable);
        @(negedge clock);
        start = 1'b1; op = o; PC = pc; SP = sp; Result = res; B = b;
        mif.mem_ready = 1'b0; mif.mem_rdata = rd;
        @(posedge clock);
        lat = 0; nstr = 0; a_s = '0; w_s = '0; re_s = 1'b0; we_s = 1'b0; unstable = 1'b0;
        for (int c = 1; c <= WL + 5; c++) begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            else begin
                op = 3'd1; PC = $urandom; SP = $urandom; Result = $urandom; B = $urandom;
            end
            if (bank_enable) begin
                lat = c;
                break;
            end
            if (mif.mem_re || mif.mem_we) begin
                if (nstr > 0 && (mif.mem_addr != a_s || mif.mem_wdata != w_s)) unstable = 1'b1;
                nstr++;
                a_s = mif.mem_addr; w_s = mif.mem_wdata;
                re_s = re_s | mif.mem_re; we_s = we_s | mif.mem_we;
            end
            mif.mem_ready = (rdy >= 0) && (nstr > rdy);
        end
        start = 1'b0; mif.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (PCin !== 32'd1 || SPin !== 32'hFFFF_FFFF || MemIn !== 32'd0 ||
            mif.mem_addr !== 32'd0 || mif.mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got pc=%h sp=%h memin=%h addr=%h wd=%h required 1/ffffffff/0/0/0",
                     PCin, SPin, MemIn, mif.mem_addr, mif.mem_wdata);
        end
        total++;
        if ({mif.mem_re, mif.mem_we, bank_enable, busy, fault} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got %b required 00000",
                     {mif.mem_re, mif.mem_we, bank_enable, busy, fault});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_nop();
        int lat, n; logic [31:0] a, w; logic re, we; bit us;
        do_op(3'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 32'd0, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 1 || PCin !== 32'd2 || SPin !== 32'hFFFF_FFFF || fault !== 1'b0 || n !== 0) begin
            bad++;
            $display("FAIL nop got lat=%0d pc=%h sp=%h f=%b n=%0d required 1/2/ffffffff/0/0",
                     lat, PCin, SPin, fault, n);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL nop_busy got %b required 1", busy);
        end
    endtask

    task automatic test_branch();
        int lat, n; logic [31:0] a, w; logic re, we; bit us;
        do_op(3'd1, 32'd2, 32'hFFFF_FFFF, 32'h40, 32'd0, 0, 32'd0, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 1 || PCin !== 32'h40 || n !== 0 || fault !== 1'b0) begin
            bad++;
            $display("FAIL branch got lat=%0d pc=%h n=%0d f=%b required 1/40/0/0", lat, PCin, n, fault);
        end
    endtask

    task automatic test_push_pop();
        int lat, n; logic [31:0] a, w; logic re, we; bit us;
        do_op(3'd4, 32'h40, 32'hFFFF_FFFF, 32'd0, 32'hAB, 2, 32'd0, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (n !== 3 || a !== 32'hFFFF_FFFE || w !== 32'hAB || we !== 1'b1 || re !== 1'b0 || us) begin
            bad++;
            $display("FAIL push_access got n=%0d addr=%h wd=%h we=%b re=%b unst=%b required 3/fffffffe/ab/1/0/0",
                     n, a, w, we, re, us);
        end
        total++;
        if (lat !== 4 || SPin !== 32'hFFFF_FFFE || PCin !== 32'h41 || fault !== 1'b0) begin
            bad++;
            $display("FAIL push_commit got lat=%0d sp=%h pc=%h f=%b required 4/fffffffe/41/0",
                     lat, SPin, PCin, fault);
        end
        do_op(3'd5, 32'h41, 32'hFFFF_FFFE, 32'd0, 32'd0, 0, 32'hAB, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 2 || MemIn !== 32'hAB || SPin !== 32'hFFFF_FFFF || a !== 32'hFFFF_FFFE || re !== 1'b1) begin
            bad++;
            $display("FAIL pop got lat=%0d memin=%h sp=%h addr=%h re=%b required 2/ab/ffffffff/fffffffe/1",
                     lat, MemIn, SPin, a, re);
        end
        do_op(3'd5, 32'h42, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 32'h77, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 1 || fault !== 1'b1 || n !== 0 || PCin !== EXC || SPin !== 32'hFFFF_FFFF || MemIn !== 32'hAB) begin
            bad++;
            $display("FAIL pop_empty got lat=%0d f=%b n=%0d pc=%h sp=%h memin=%h required 1/1/0/2/ffffffff/ab",
                     lat, fault, n, PCin, SPin, MemIn);
        end
        do_op(3'd4, 32'h50, LIM, 32'd0, 32'h99, 0, 32'd0, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 1 || fault !== 1'b1 || n !== 0 || PCin !== EXC || SPin !== LIM) begin
            bad++;
            $display("FAIL push_limit got lat=%0d f=%b n=%0d pc=%h sp=%h required 1/1/0/2/8000",
                     lat, fault, n, PCin, SPin);
        end
    endtask

    task automatic test_timeout();
        int lat, n; logic [31:0] a, w; logic re, we; bit us;
        do_op(3'd2, 32'h60, 32'h1000, 32'h1234, 32'd0, -1, 32'h55, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== WL + 2 || fault !== 1'b1 || MemIn !== 32'hAB || PCin !== EXC || SPin !== 32'h1000) begin
            bad++;
            $display("FAIL timeout got lat=%0d f=%b memin=%h pc=%h sp=%h required %0d/1/ab/2/1000",
                     lat, fault, MemIn, PCin, SPin, WL + 2);
        end
        total++;
        if (n !== WL + 1 || a !== 32'h1234 || re !== 1'b1) begin
            bad++;
            $display("FAIL timeout_strobe got n=%0d addr=%h re=%b required %0d/1234/1", n, a, re, WL + 1);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, n; logic [31:0] a, w; logic re, we; bit us;
        do_op(3'd3, 32'h70, 32'h2000, 32'h300, 32'hC0DE, 1, 32'd0, 1'b1, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 3 || PCin !== 32'h71 || SPin !== 32'h2000 || a !== 32'h300 || w !== 32'hC0DE || us) begin
            bad++;
            $display("FAIL busy_ignore got lat=%0d pc=%h sp=%h addr=%h wd=%h unst=%b required 3/71/2000/300/c0de/0",
                     lat, PCin, SPin, a, w, us);
        end
        @(negedge clock);
        total++;
        if (bank_enable !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL commit_pulse got be=%b busy=%b required 0/0", bank_enable, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, n; logic [31:0] a, w; logic re, we; bit us;
        do_op(3'd6, 32'h80, 32'h10, 32'd0, 32'd0, 0, 32'd0, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 1 || PCin !== EXC || fault !== 1'b0) begin
            bad++;
            $display("FAIL except got lat=%0d pc=%h f=%b required 1/2/0", lat, PCin, fault);
        end
        do_op(3'd7, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'd0, 0, 32'd0, 1'b0, lat, n, a, w, re, we, us);
        total++;
        if (lat !== 1 || PCin !== 32'd0 || SPin !== 32'h10) begin
            bad++;
            $display("FAIL b2b_reserved got lat=%0d pc=%h sp=%h required 1/0/10", lat, PCin, SPin);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clock);
        start = 1'b1; op = 3'd2; PC = 32'h90; SP = 32'h5; Result = 32'h444;
        mif.mem_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        total++;
        if (mif.mem_re !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre got re=%b required 1", mif.mem_re);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({mif.mem_re, mif.mem_we, bank_enable, busy, fault} !== 5'b0 || PCin !== 32'd1 ||
            SPin !== 32'hFFFF_FFFF || MemIn !== 32'd0 || mif.mem_addr !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid got ctl=%b pc=%h sp=%h memin=%h addr=%h required 00000/1/ffffffff/0/0",
                     {mif.mem_re, mif.mem_we, bank_enable, busy, fault}, PCin, SPin, MemIn, mif.mem_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        mif.mem_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bank_enable || busy) seen++;
        end
        mif.mem_ready = 1'b0;
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_mid_after got active_cycles=%0d required 0", seen);
        end
        m_memin = 32'd0;
    endtask

    task automatic test_random();
        int lat, n, elat, estr, rdy; logic [31:0] a, w, epc, esp, eaddr, pc, sp, res, b, rd;
        logic re, we, ef, ere, ewe; bit us; logic [2:0] o;
        for (int k = 0; k < 40; k++) begin
            o   = 3'($urandom_range(0, 7));
            pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            case ($urandom_range(0, 7))
                0: sp = LIM;
                1: sp = 32'hFFFF_FFFF;
                2: sp = 32'd0;
                default: sp = $urandom;
            endcase
            res = $urandom; b = $urandom; rd = $urandom;
            rdy = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            model(o, pc, sp, res, rdy, rd, epc, esp, eaddr, ef, ere, ewe, elat, estr);
            do_op(o, pc, sp, res, b, rdy, rd, 1'b0, lat, n, a, w, re, we, us);
            total++;
            if (lat !== elat || PCin !== epc || SPin !== esp || fault !== ef || MemIn !== m_memin) begin
                bad++;
                $display("FAIL rand_commit[%0d] op=%0d got lat=%0d pc=%h sp=%h f=%b memin=%h required %0d/%h/%h/%b/%h",
                         k, o, lat, PCin, SPin, fault, MemIn, elat, epc, esp, ef, m_memin);
            end
            total++;
            if (n !== estr || re !== ere || we !== ewe || us ||
                (estr > 0 && a !== eaddr) || (ewe && w !== b)) begin
                bad++;
                $display("FAIL rand_access[%0d] op=%0d got n=%0d re=%b we=%b addr=%h wd=%h unst=%b required %0d/%b/%b/%h/%h/0",
                         k, o, n, re, we, a, w, us, estr, ere, ewe, eaddr, b);
            end
        end
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'd0;
        m_memin = 32'd0;
        test_reset();
        test_nop();
        test_branch();
        test_push_pop();
        test_timeout();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_addr_handler.md
# mem_addr_handler

Memory address handler sitting directly upstream of the register bank. It consumes the bank's current PC and SP, sequences one instruction-fetch/data access against the memory port, and produces the next PC (`PCin`), the next SP (`SPin`), and the latched load word (`MemIn`). It also generates the single-cycle bank write enable that commits all three.

## Interface

Parameters:
- `EXC_VECTOR`, default 32'h0000_0002: PC loaded on an exception or an access fault.
- `STACK_LIMIT`, default 32'h0000_8000: lowest legal SP; a PUSH at this SP faults.
- `WAIT_LIMIT`, default 8: maximum number of `mem_ready` wait cycles before a timeout fault.

Ports (name, direction, width, meaning):
- `clock`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request one operation; sampled only in IDLE.
- `op`, in, 3: 0 NOP, 1 BRANCH, 2 LOAD, 3 STORE, 4 PUSH, 5 POP, 6 EXCEPT, 7 reserved (treated as NOP).
- `PC`, in, 32: current PC from the bank.
- `SP`, in, 32: current mode-selected SP from the bank.
- `Result`, in, 32: ALU output; used as the branch target or the LOAD/STORE address.
- `B`, in, 32: store/push data.
- `mem_rdata`, in, 32: memory read data.
- `mem_ready`, in, 1: memory accepted the write, or the read data is valid.
- `mem_addr`, out, 32: memory word address.
- `mem_wdata`, out, 32: memory write data.
- `mem_re`, out, 1: read strobe.
- `mem_we`, out, 1: write strobe.
- `PCin`, out, 32: next PC to the bank.
- `SPin`, out, 32: next SP to the bank.
- `MemIn`, out, 32: latched load data to the bank.
- `bank_enable`, out, 1: one-cycle commit pulse to the bank `enable`.
- `busy`, out, 1: high in every state except IDLE.
- `fault`, out, 1: qualifies `bank_enable`; the operation aborted.

## Operation

FSM states are IDLE, ACCESS and COMMIT.

IDLE:
- On `start`, latch `op`, `PC`, `SP`, `Result` and `B`.
- Memory ops (2–5) go to ACCESS; all other ops go to COMMIT.

ACCESS:
- Drive `mem_addr`, `mem_re`/`mem_we` and `mem_wdata` from the latched values, held stable until `mem_ready`.
- Per-op behaviour:
  - LOAD reads at Result.
  - STORE writes B at Result.
  - PUSH writes B at SP−1.
  - POP reads at SP.
- When `mem_ready` is seen, the wait counter clears, read data is captured into `MemIn`, and the FSM goes to COMMIT.
- The wait counter increments on each cycle without `mem_ready`. When the count reaches `WAIT_LIMIT`, the FSM sets the fault condition, drops the strobes and goes to COMMIT.

COMMIT:
- `bank_enable` is 1 for exactly this cycle, then the FSM returns to IDLE.
- `PCin` for a normal completion:
  - NOP, LOAD, STORE, PUSH, POP and reserved: PC+1 (mod 2^32).
  - BRANCH: Result.
  - EXCEPT: `EXC_VECTOR`.
- `SPin` for a normal completion: PUSH gives SP−1, POP gives SP+1, all other ops give SP.
- On a fault: `PCin` = `EXC_VECTOR`, `SPin` = SP (unchanged), `fault` = 1, and `MemIn` is unchanged.

Fault conditions:
- PUSH with SP == `STACK_LIMIT` faults without a memory access: IDLE goes straight to COMMIT with fault.
- POP with SP == 32'hFFFF_FFFF (empty stack) faults the same way.
- Memory timeout, as described under ACCESS.

General rules:
- `start` is ignored while `busy` is high.
- Address arithmetic wraps modulo 2^32. The SP bounds above are the only range checks.
- Outputs are registered. `PCin`/`SPin` hold their last committed values outside COMMIT.

Reset values (applied immediately on `reset`, mid-operation included; no memory strobe survives reset):
- State IDLE.
- `PCin` = 1, `SPin` = 32'hFFFF_FFFF, `MemIn` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- `mem_re`, `mem_we`, `bank_enable`, `busy`, `fault` all 0; wait counter 0.

## Timing

- Non-memory op: `start` is sampled at edge 0, and COMMIT (`bank_enable` = 1) holds during cycle 1. Latency is 1.
- Memory op with `mem_ready` already high in the first ACCESS cycle: ACCESS is cycle 1, COMMIT is cycle 2. Each wait cycle adds 1.
- Timeout: COMMIT occurs in cycle `WAIT_LIMIT`+2 after `start`.
- The earliest back-to-back `start` is accepted in the cycle after COMMIT (IDLE).
- `mem_re`/`mem_we` assert on the edge entering ACCESS and deassert on the edge leaving ACCESS.

## Structure

- Shared package `armaria_pkg`:
  - op encoding constants (OP_NOP … OP_EXCEPT);
  - state enum;
  - default `EXC_VECTOR` and reset constants for PC and SP.
- One natural sub-module: `next_addr_calc`, purely combinational. Inputs are latched op, PC, SP, Result and fault; outputs are next PC, next SP and access address.
- FSM and registers live in the top module.

## Test plan

- Reset then NOP with PC=1 → `bank_enable` 1 cycle later, `PCin`=2, `SPin`=FFFF_FFFF, `fault`=0.
- BRANCH with Result=0x40 → `PCin`=0x40, latency 1, no memory strobe.
- PUSH with SP=FFFF_FFFF, B=0xAB, `mem_ready` delayed 2 cycles → write at FFFF_FFFE held 3 cycles; COMMIT gives `SPin`=FFFF_FFFE.
- Then POP with SP=FFFF_FFFE, `mem_rdata`=0xAB → `MemIn`=0xAB, `SPin`=FFFF_FFFF. Then POP at FFFF_FFFF → `fault`=1, no strobe, `PCin`=`EXC_VECTOR`.
- LOAD with `mem_ready` held low → timeout COMMIT at cycle 10 (`WAIT_LIMIT`=8), `fault`=1, `MemIn` unchanged.
- Reset asserted during ACCESS → strobes drop the same cycle, all outputs return to reset values, and no `bank_enable` follows.
